// File: rtl/sampled_change_monitor_if.sv
// Signal bundle between a sampled_change_monitor and whatever drives and observes it.
// The master drives the sampled values and per-channel modes; the slave returns the results.
interface sampled_change_monitor_if #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic                      sample_en;
  logic                      clr;
  logic [CHANNELS*WIDTH-1:0] val;
  logic [2*CHANNELS-1:0]     mode;
  logic [CHANNELS-1:0]       changed;
  logic [CHANNELS-1:0]       stable;
  logic [CHANNELS-1:0]       rose;
  logic [CHANNELS-1:0]       fell;
  logic [CHANNELS*WIDTH-1:0] past_val;
  logic                      hist_valid;
  logic [CHANNELS-1:0]       fail;
  logic                      fail_sticky;
  logic [CNT_W-1:0]          fail_count;
  logic [CNT_W-1:0]          sample_count;
  logic [CNT_W-1:0]          first_fail_idx;
  logic [CH_W-1:0]           first_fail_chan;

  modport master (
    output sample_en, clr, val, mode,
    input  changed, stable, rose, fell, past_val, hist_valid, fail,
           fail_sticky, fail_count, sample_count, first_fail_idx, first_fail_chan
  );

  modport slave (
    input  sample_en, clr, val, mode,
    output changed, stable, rose, fell, past_val, hist_valid, fail,
           fail_sticky, fail_count, sample_count, first_fail_idx, first_fail_chan
  );
endinterface

// File: rtl/sampled_change_monitor.sv
// Multi-channel sampled-value monitor: registered $changed/$stable/$rose/$fell/$past results,
// per-channel expectation checks, saturating counters and first-failure capture.
module sampled_change_monitor #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 2,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  sampled_change_monitor_if.slave   bus
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == {CNT_W{1'b1}}) ? x : x + 1'b1;
  endfunction

  logic [CHANNELS*WIDTH-1:0] prev_p0;
  logic [CHANNELS*WIDTH-1:0] hist_p0 [DEPTH];
  logic [DEPTH-1:0]          hvld_p0;
  logic                      have_prev_p0;
  logic [CHANNELS-1:0]       chg_d, stb_d, rose_d, fell_d, fail_d;
  logic [CH_W-1:0]           low_d;

  always_comb begin
    chg_d  = '0;
    stb_d  = '0;
    rose_d = '0;
    fell_d = '0;
    fail_d = '0;
    low_d  = '0;
    // Sample 0 has no prior value, so every result and check stays 0.
    if (have_prev_p0) begin
      for (int c = 0; c < CHANNELS; c++) begin
        chg_d[c]  = (bus.val[c*WIDTH +: WIDTH] != prev_p0[c*WIDTH +: WIDTH]);
        stb_d[c]  = (bus.val[c*WIDTH +: WIDTH] == prev_p0[c*WIDTH +: WIDTH]);
        rose_d[c] = !prev_p0[c*WIDTH] && bus.val[c*WIDTH];
        fell_d[c] = prev_p0[c*WIDTH] && !bus.val[c*WIDTH];
        case (bus.mode[2*c +: 2])
          2'b01:   fail_d[c] = !chg_d[c];
          2'b10:   fail_d[c] = !stb_d[c];
          2'b11:   fail_d[c] = !rose_d[c];
          default: fail_d[c] = 1'b0;
        endcase
      end
    end
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (fail_d[c]) low_d = CH_W'(c);
    end
  end

  // Stage p0 -> outputs: history, counters and registered results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_p0              <= '0;
      for (int i = 0; i < DEPTH; i++) hist_p0[i] <= '0;
      hvld_p0              <= '0;
      have_prev_p0         <= 1'b0;
      bus.changed          <= '0;
      bus.stable           <= '0;
      bus.rose             <= '0;
      bus.fell             <= '0;
      bus.fail             <= '0;
      bus.fail_sticky      <= 1'b0;
      bus.fail_count       <= '0;
      bus.sample_count     <= '0;
      bus.first_fail_idx   <= '0;
      bus.first_fail_chan  <= '0;
    end else begin
      bus.changed <= bus.sample_en ? chg_d  : '0;
      bus.stable  <= bus.sample_en ? stb_d  : '0;
      bus.rose    <= bus.sample_en ? rose_d : '0;
      bus.fell    <= bus.sample_en ? fell_d : '0;
      bus.fail    <= bus.sample_en ? fail_d : '0;
      if (bus.sample_en) begin
        prev_p0          <= bus.val;
        hist_p0[0]       <= bus.val;
        hvld_p0[0]       <= 1'b1;
        for (int i = 1; i < DEPTH; i++) begin
          hist_p0[i] <= hist_p0[i-1];
          hvld_p0[i] <= hvld_p0[i-1];
        end
        have_prev_p0     <= 1'b1;
        bus.sample_count <= sat_inc(bus.sample_count);
      end
      // clr beats a simultaneous violation; the fail pulse above is still emitted.
      if (bus.clr) begin
        bus.fail_sticky     <= 1'b0;
        bus.fail_count      <= '0;
        bus.first_fail_idx  <= '0;
        bus.first_fail_chan <= '0;
      end else if (bus.sample_en && (|fail_d)) begin
        bus.fail_count <= sat_inc(bus.fail_count);
        if (!bus.fail_sticky) begin
          bus.fail_sticky     <= 1'b1;
          bus.first_fail_idx  <= bus.sample_count;
          bus.first_fail_chan <= low_d;
        end
      end
    end
  end

  assign bus.past_val   = hist_p0[DEPTH-1];
  assign bus.hist_valid = hvld_p0[DEPTH-1];
endmodule

// File: doc/sampled_change_monitor.md
# sampled_change_monitor

Parametrised, multi-channel sampled-value monitor that implements the $changed / $stable / $rose / $fell / $past(val, DEPTH) semantics of concurrent assertions in synthesizable RTL. A per-channel mode selects an expectation, and the block flags violations, counts them and captures the first failure. It sits beside the DUT in assertion-regression benches as a golden reference for simulator assertion results, and also serves as an on-chip checker.

## Interface
- WIDTH, 1: bits per channel value.
- CHANNELS, 4: number of independent monitored channels.
- DEPTH, 2: history depth for past_val, ≥1.
- CNT_W, 16: width of the sample and failure counters.
- CH_W, max(1, $clog2(CHANNELS)): derived channel-index width.
- clk  in  1  sampling clock. One clock only; the block samples on its rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- sample_en  in  1  sampling event qualifier; no state advances when it is 0.
- clr  in  1  synchronous clear of counters and failure capture only. History is not cleared.
- val  in  CHANNELS*WIDTH  monitored values; channel c occupies [c*WIDTH +: WIDTH].
- mode  in  2*CHANNELS  per-channel expectation: 00 off, 01 expect changed, 10 expect stable, 11 expect rose (LSB of the channel).
- changed, stable, rose, fell  out  CHANNELS each  registered per-channel results. rose and fell use the channel LSB.
- past_val  out  CHANNELS*WIDTH  value sampled DEPTH samples ago.
- hist_valid  out  1  at least DEPTH samples have been taken since reset.
- fail  out  CHANNELS  one-cycle per-channel violation pulse.
- fail_sticky  out  1  a violation has occurred since reset or clr.
- fail_count  out  CNT_W  number of sampled cycles with ≥1 violation, saturating.
- sample_count  out  CNT_W  samples taken, saturating.
- first_fail_idx  out  CNT_W  sample index (0-based) of the first violation.
- first_fail_chan  out  CH_W  lowest failing channel in that sample.

## Operation
- Sample: a rising edge with rst_n=1 and sample_en=1. Sample index k is the value of sample_count before the edge.
- prev register holds the previous sample. history is a DEPTH-deep shift register. On each sample: prev<=val and history shifts in val.
- For each channel, the block compares the current val against the prior prev:
  - changed = (val≠prev)
  - stable = (val==prev)
  - rose = prev[lsb]==0 && val[lsb]==1
  - fell = prev[lsb]==1 && val[lsb]==0
- No-prior rule: on sample 0 there is no prior value. changed, stable, rose, fell and fail are all 0, and no checks are performed. This is the "skip first cycle" behaviour.
- Check for channel c with mode≠00: the check fails if the expected flag is 0. Mode 01 checks changed, 10 checks stable, 11 checks rose. The fail[c] pulse is asserted for the cycle after the sample.
- Counters and capture:
  - fail_count increments by 1 per sample with any fail bit set, independent of the number of failing channels.
  - On the first violating sample, first_fail_idx is set to k and first_fail_chan to the lowest failing c. Both are frozen until clr or reset.
  - sample_count and fail_count saturate at 2^CNT_W−1.
- hist_valid rises once DEPTH samples are taken. Before that, past_val shows reset contents (0).
- mode changes take effect on the next sample. They do not affect history.

## Timing
- Latency: result outputs (changed, stable, rose, fell, fail) are registered, valid in the cycle after the sampling edge.
- On a non-sampling cycle (sample_en=0):
  - changed, stable, rose, fell and fail drop to 0.
  - history, counters and captures hold.
- Reset (rst_n=0 at an edge) clears all state and outputs to 0, including prev, history, hist_valid and both counters. This applies mid-operation as well; the next sample is then treated as sample 0.
- clr=1 at an edge:
  - Clears fail_sticky, fail_count, first_fail_idx and first_fail_chan.
  - Does not clear sample_count, prev or history.
  - clr has priority over a simultaneous violation: counters and captures read 0 afterwards, but the fail pulse for that sample is still emitted.
- Simultaneous reset and clr: reset wins.
- DEPTH=1: past_val equals prev. hist_valid rises after the first sample.

## Test plan
- CHANNELS=1, WIDTH=1, mode=01, val toggling each sample for 12 samples -> changed=1 from sample 1 on, fail never asserts, fail_count=0, sample_count=12.
- Same stimulus, but val is held at 1 on sample 5 -> fail pulses once one cycle after sample 5, fail_count=1, first_fail_idx=5, first_fail_chan=0, fail_sticky=1.
- CHANNELS=4, modes {01,10,11,00}, all channels failing on sample 3 -> fail=4'b0111, fail_count increments by exactly 1, first_fail_chan=0.
- DEPTH=3, WIDTH=8, samples 0x11,0x22,0x33,0x44 -> hist_valid rises after the 3rd sample; after the 4th sample past_val=0x22. With sample_en=0 for 5 cycles interleaved, nothing changes.
- rst_n driven low mid-run after 7 samples, then released -> all outputs 0; the next sample produces no check and no fail, even when val equals the pre-reset value.
- clr asserted together with a violating sample -> fail pulse present; afterwards fail_count=0, fail_sticky=0, sample_count still counting.
